// File: rtl/fc_pkg.sv
// Shared types and default constants for the FC chain write sequencer.
package fc_pkg;

  typedef enum logic [2:0] {IDLE, GAP, WREN, SHIFT, TAIL} fc_state_t;

  localparam int unsigned FC_BITS_DEF = 48;
  localparam int unsigned FCWRTEN_DEF = 15;
  localparam int unsigned WRTFC_DEF   = 5;

endpackage

// File: rtl/fc_sclk_tick.sv
// SCLK falling-edge detector: tick is high for the clk cycle following an SCLK fall.
module fc_sclk_tick (
  input  logic clk,
  input  logic rst,
  input  logic SCLK,
  output logic tick
);

  logic sclk_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_q <= 1'b0;
    end else begin
      sclk_q <= SCLK;
    end
  end

  assign tick = sclk_q & ~SCLK;

endmodule

// File: rtl/fc_chain_sequencer.sv
// FC write sequencer for a daisy chain of LED drivers: FCWRTEN latch pulse, then the FC word
// shifted once per driver with the WRTFC latch on the final bits.
module fc_chain_sequencer
  import fc_pkg::*;
#(
  parameter int unsigned N_DRIVERS    = 1,
  parameter int unsigned FC_BITS      = FC_BITS_DEF,
  parameter int unsigned FCWRTEN_CLKS = FCWRTEN_DEF,
  parameter int unsigned WRTFC_CLKS   = WRTFC_DEF,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               SCLK,
  input  logic               force_fc,
  input  logic [FC_BITS-1:0] fc_word,
  output logic               LAT,
  output logic               SIN,
  output logic               en,
  output logic               done
);

  localparam int unsigned SHIFT_LEN = N_DRIVERS * FC_BITS;
  localparam int unsigned CNT_W     = $clog2(SHIFT_LEN + 1);
  localparam int unsigned BIT_W     = $clog2(FC_BITS);

  localparam logic [CNT_W-1:0] WREN_LAST  = CNT_W'(FCWRTEN_CLKS - 1);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SHIFT_LEN - 1);
  localparam logic [CNT_W-1:0] LAT_FROM   = CNT_W'(SHIFT_LEN - WRTFC_CLKS);
  localparam logic [BIT_W-1:0] BIT_TOP    = BIT_W'(FC_BITS - 1);

  logic                tick;
  fc_state_t           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [FC_BITS-1:0]  word_q, word_d;
  logic                pending_q, pending_d;
  logic                lat_q, lat_d;
  logic                sin_q, sin_d;
  logic                done_q, done_d;

  fc_sclk_tick u_tick (
    .clk  (clk),
    .rst  (rst),
    .SCLK (SCLK),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= AUTO_START ? GAP : IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      word_q    <= '0;
      pending_q <= 1'b0;
      lat_q     <= 1'b0;
      sin_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      word_q    <= word_d;
      pending_q <= pending_d;
      lat_q     <= lat_d;
      sin_q     <= sin_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    word_d    = word_q;
    pending_d = pending_q;
    done_d    = 1'b0;

    if (force_fc && state_q != IDLE) begin
      pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (force_fc) begin
          state_d = GAP;
        end
      end
      GAP: begin
        // Single capture point on leaving GAP also covers the auto-start after reset.
        if (tick) begin
          state_d = WREN;
          cnt_d   = '0;
          word_d  = fc_word;
        end
      end
      WREN: begin
        if (tick) begin
          if (cnt_q == WREN_LAST) begin
            state_d = SHIFT;
            cnt_d   = '0;
            bit_d   = BIT_TOP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      SHIFT: begin
        if (tick) begin
          if (cnt_q == SHIFT_LAST) begin
            state_d = TAIL;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            bit_d = (bit_q == '0) ? BIT_TOP : bit_q - BIT_W'(1);
          end
        end
      end
      TAIL: begin
        if (tick) begin
          done_d    = 1'b1;
          cnt_d     = '0;
          pending_d = 1'b0;
          state_d   = (pending_q || force_fc) ? GAP : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    lat_d = (state_d == WREN) || ((state_d == SHIFT) && (cnt_d >= LAT_FROM));
    sin_d = (state_d == SHIFT) && word_d[bit_d];
  end

  assign LAT  = lat_q;
  assign SIN  = sin_q;
  assign done = done_q;
  assign en   = (state_q != IDLE);

endmodule

// File: tb/tb_fc_chain_sequencer.sv
// Bench for fc_chain_sequencer: three instances (default, 3-driver chain, no auto-start)
// checked every SCLK rise against a queue of expected LAT/SIN samples.
module tb_fc_chain_sequencer;

  logic        clk  = 1'b0;
  logic        SCLK = 1'b0;
  int          div  = 0;
  logic [2:0]  rst_n;
  logic [2:0]  force_fc;
  logic [2:0]  lat, sin, en, done;
  logic [47:0] word [3];

  // Expected sample per SCLK rise: {last_of_sequence, LAT, SIN}.
  logic [2:0]  exp_q [3][$];
  logic [1:0]  rec [$];
  bit          rec_on = 1'b0;
  int          seq_len [3] = '{65, 161, 65};
  int          dn [3] = '{0, 0, 0};
  int          exp_dn [3] = '{0, 0, 0};
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (div == 3) begin
      div  <= 0;
      SCLK <= ~SCLK;
    end else begin
      div <= div + 1;
    end
  end

  fc_chain_sequencer #(.N_DRIVERS(1)) u_d0 (
    .clk(clk), .rst(rst_n[0]), .SCLK(SCLK), .force_fc(force_fc[0]), .fc_word(word[0]),
    .LAT(lat[0]), .SIN(sin[0]), .en(en[0]), .done(done[0])
  );
  fc_chain_sequencer #(.N_DRIVERS(3)) u_d1 (
    .clk(clk), .rst(rst_n[1]), .SCLK(SCLK), .force_fc(force_fc[1]), .fc_word(word[1]),
    .LAT(lat[1]), .SIN(sin[1]), .en(en[1]), .done(done[1])
  );
  fc_chain_sequencer #(.AUTO_START(1'b0)) u_d2 (
    .clk(clk), .rst(rst_n[2]), .SCLK(SCLK), .force_fc(force_fc[2]), .fc_word(word[2]),
    .LAT(lat[2]), .SIN(sin[2]), .en(en[2]), .done(done[2])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_seq(input int d, input logic [47:0] w);
    int l;
    l = ((d == 1) ? 3 : 1) * 48;
    exp_q[d].push_back(3'b000);
    repeat (15) exp_q[d].push_back(3'b010);
    for (int k = 0; k < l; k++) begin
      exp_q[d].push_back({1'b0, (k >= l - 5), w[47 - (k % 48)]});
    end
    exp_q[d].push_back(3'b100);
  endtask

  task automatic sync_low();
    @(negedge SCLK);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rises(input int n);
    repeat (n) @(posedge SCLK);
    #2;
  endtask

  task automatic pulse_force(input int d);
    bit was_idle;
    sync_low();
    was_idle    = (exp_q[d].size() == 0);
    force_fc[d] = 1'b1;
    @(posedge clk);
    #1;
    force_fc[d] = 1'b0;
    if (was_idle) check($sformatf("d%0d_en_next_clk", d), en[d], 1'b1);
    if (was_idle || exp_q[d].size() <= seq_len[d]) push_seq(d, word[d]);
  endtask

  // Force sampled on the same clk edge that acts on the SCLK fall.
  task automatic pulse_force_at_tick(input int d);
    @(negedge SCLK);
    #1;
    force_fc[d] = 1'b1;
    @(posedge clk);
    #1;
    force_fc[d] = 1'b0;
    push_seq(d, word[d]);
  endtask

  always @(posedge SCLK) begin
    logic [2:0] e;
    #1;
    for (int d = 0; d < 3; d++) begin
      if (rst_n[d] === 1'b1) begin
        if (exp_q[d].size() > 0) begin
          e = exp_q[d].pop_front();
          check($sformatf("d%0d_lat", d), lat[d], e[1]);
          check($sformatf("d%0d_sin", d), sin[d], e[0]);
          check($sformatf("d%0d_en_busy", d), en[d], 1'b1);
          if (e[2]) exp_dn[d]++;
        end else begin
          check($sformatf("d%0d_lat_idle", d), lat[d], 1'b0);
          check($sformatf("d%0d_sin_idle", d), sin[d], 1'b0);
          check($sformatf("d%0d_en_idle", d), en[d], 1'b0);
        end
      end
    end
    if (rec_on) rec.push_back({lat[0], sin[0]});
  end

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (done[d] === 1'b1) dn[d]++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          runs [$];
    int          cur;
    int          guard;
    int          lit [5] = '{1, 15, 43, 5, 1};
    logic [47:0] got;
    logic        zero_or;

    rst_n    = 3'b000;
    force_fc = 3'b000;
    word[0]  = 48'h0;
    word[1]  = 48'h8000_0000_0001;
    word[2]  = 48'h0;
    repeat (5) @(posedge clk);

    // Reset state
    check("d0_rst_lat", lat[0], 1'b0);
    check("d0_rst_en", en[0], 1'b1);
    check("d2_rst_en", en[2], 1'b0);
    check("d1_rst_done", done[1], 1'b0);

    // Auto-start: defaults with word 0, 3-driver chain, no-auto instance stays idle
    sync_low();
    rst_n = 3'b111;
    push_seq(0, word[0]);
    push_seq(1, word[1]);
    rec.delete();
    rec_on = 1'b1;
    check("model_len_n1", exp_q[0].size(), 65);
    check("model_len_n3", exp_q[1].size(), 161);
    check("model_n3_sin_k0", exp_q[1][16][0], 1'b1);
    check("model_n3_sin_k1", exp_q[1][17][0], 1'b0);
    check("model_n3_sin_k47", exp_q[1][63][0], 1'b1);
    check("model_n3_sin_k48", exp_q[1][64][0], 1'b1);
    check("model_n3_lat_r139", exp_q[1][16 + 138][1], 1'b0);
    check("model_n3_lat_r140", exp_q[1][16 + 139][1], 1'b1);
    check("model_n3_lat_r144", exp_q[1][16 + 143][1], 1'b1);
    check("model_n3_tail", exp_q[1][160], 3'b100);
    wait_rises(170);
    rec_on = 1'b0;

    check("t1_rec_len", rec.size() >= 65, 1'b1);
    if (rec.size() >= 65) begin
      check("t1_first_lat", rec[0][1], 1'b0);
      cur = 1;
      for (int i = 1; i < 65; i++) begin
        if (rec[i][1] == rec[i-1][1]) begin
          cur++;
        end else begin
          runs.push_back(cur);
          cur = 1;
        end
      end
      runs.push_back(cur);
      check("t1_run_count", runs.size(), 5);
      for (int i = 0; i < 5; i++) begin
        if (i < runs.size()) check($sformatf("t1_run%0d", i), runs[i], lit[i]);
      end
    end
    check("t1_done_d0", dn[0], 1);
    check("t1_done_d1", dn[1], 1);
    check("t1_done_d2", dn[2], 0);

    // Word pattern MSB first; later word change must not disturb; no-auto instance started
    word[0] = 48'hA5A5_0F0F_C3C3;
    pulse_force(0);
    rec.delete();
    rec_on = 1'b1;
    pulse_force(2);
    wait_rises(30);
    word[0] = 48'hFFFF_FFFF_FFFF;
    wait_rises(45);
    rec_on = 1'b0;
    check("t2_rec_len", rec.size() >= 65, 1'b1);
    if (rec.size() >= 65) begin
      zero_or = 1'b0;
      for (int k = 0; k < 48; k++) got[47 - k] = rec[16 + k][0];
      for (int i = 0; i < 16; i++) zero_or |= rec[i][0];
      zero_or |= rec[64][0];
      check("t2_sin_word", got, 48'hA5A5_0F0F_C3C3);
      check("t2_sin_zero_outside", zero_or, 1'b0);
    end
    check("t2_done_d0", dn[0], exp_dn[0]);
    check("t2_done_d2", dn[2], 1);

    // Re-trigger mid-shift with a new word; a second request collapses into the first
    word[0] = 48'h1111_2222_3333;
    pulse_force(0);
    wait_rises(35);
    word[0] = 48'hDEAD_BEEF_0123;
    pulse_force(0);
    pulse_force(0);
    guard = 0;
    while (exp_q[0].size() != 0 && guard < 400) begin
      @(posedge SCLK);
      #2;
      guard++;
    end
    check("t4_drain", guard < 400, 1'b1);
    word[0] = 48'h0F0F_0F0F_0F0F;
    pulse_force_at_tick(0);
    wait_rises(70);
    check("t4_done_d0", dn[0], exp_dn[0]);
    check("t4_done_total", dn[0], 5);

    // Reset during WREN rise 7 aborts immediately, then auto-restarts
    pulse_force(0);
    wait_rises(8);
    check("t5_lat_before", lat[0], 1'b1);
    rst_n[0] = 1'b0;
    #1;
    check("t5_lat_abort", lat[0], 1'b0);
    check("t5_sin_abort", sin[0], 1'b0);
    check("t5_en_in_reset", en[0], 1'b1);
    exp_q[0].delete();
    repeat (3) @(posedge clk);
    sync_low();
    rst_n[0] = 1'b1;
    push_seq(0, word[0]);
    wait_rises(70);

    for (int d = 0; d < 3; d++) check($sformatf("final_done_d%0d", d), dn[d], exp_dn[d]);
    check("final_done_d0_lit", dn[0], 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
